// File: rtl/ifu_icache_sa.sv
// Set-associative IFU instruction cache: per-set tree-PLRU replacement, blocking
// single-miss line fill, and a single-cycle invalidate-all flush.
module ifu_icache_sa #(
  parameter int CL_WIDTH = 128,
  parameter int WAYS_NUM = 4,
  parameter int SETS_NUM = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                core_req_valid,
  input  logic [31:0]         core_req_pc,
  output logic                core_req_ready,
  output logic                core_rsp_valid,
  output logic [31:0]         core_rsp_instr,
  output logic [31:0]         core_rsp_pc,
  input  logic                flush,
  output logic                mem_req_valid,
  output logic [31:0]         mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rsp_addr,
  input  logic [CL_WIDTH-1:0] mem_rsp_data,
  output logic [1:0]          state_dbg
);

  // Handshakes: core_req and mem_req transfer on a rising edge where valid && ready
  // are both high; the sender keeps valid and payload stable until that edge.
  // mem_rsp has no ready: it is consumed only in MISS_WAIT when its line matches.

  localparam int OFFSET_W  = $clog2(CL_WIDTH / 8);
  localparam int INDEX_W   = $clog2(SETS_NUM);
  localparam int TAG_W     = 32 - OFFSET_W - INDEX_W;
  localparam int PLRU_BITS = WAYS_NUM - 1;
  localparam int WAY_W     = $clog2(WAYS_NUM);
  localparam int WORD_W    = OFFSET_W - 2;
  localparam int SET_W     = (INDEX_W > 0) ? INDEX_W : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WAYS_NUM-1:0]  valid_q [SETS_NUM];
  logic [PLRU_BITS-1:0] plru_q  [SETS_NUM];
  logic [TAG_W-1:0]     tag_q   [SETS_NUM][WAYS_NUM];
  logic [CL_WIDTH-1:0]  data_q  [SETS_NUM][WAYS_NUM];

  logic [31:0]         miss_pc_q;
  logic [SET_W-1:0]    req_set, miss_set;
  logic [TAG_W-1:0]    req_tag, miss_tag;
  logic [WORD_W-1:0]   req_word, miss_word;
  logic [WAYS_NUM-1:0] hit_vec;
  logic [WAY_W-1:0]    hit_way, victim_way;
  logic                hit, accept, fill, rsp_match;
  logic [31:0]         hit_instr, fill_instr;
  logic                unused_addr_bits;

  assign req_tag   = core_req_pc[31 -: TAG_W];
  assign miss_tag  = miss_pc_q[31 -: TAG_W];
  assign req_word  = core_req_pc[OFFSET_W-1:2];
  assign miss_word = miss_pc_q[OFFSET_W-1:2];

  generate
    if (INDEX_W > 0) begin : g_index
      assign req_set  = core_req_pc[OFFSET_W +: SET_W];
      assign miss_set = miss_pc_q[OFFSET_W +: SET_W];
    end else begin : g_no_index
      assign req_set  = '0;
      assign miss_set = '0;
    end
  endgenerate

  assign unused_addr_bits = ^mem_rsp_addr[OFFSET_W-1:0];

  function automatic logic [31:0] word_of(input logic [CL_WIDTH-1:0] line,
                                          input logic [WORD_W-1:0]   word);
    logic [CL_WIDTH-1:0] sh;
    sh = line >> {word, 5'b0};
    return sh[31:0];
  endfunction

  // Walk from the root, each node bit steering toward the subtree holding the victim.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_BITS-1:0] bits);
    logic [PLRU_BITS-1:0] sh;
    int node;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = bits >> node;
      node = 2 * node + 1 + (sh[0] ? 1 : 0);
    end
    return WAY_W'(node - PLRU_BITS);
  endfunction

  // Climb from the accessed leaf; a left child sets its parent to 1 (point right).
  function automatic logic [PLRU_BITS-1:0] plru_touch(input logic [PLRU_BITS-1:0] bits,
                                                      input logic [WAY_W-1:0]     way);
    logic [PLRU_BITS-1:0] b;
    int node, parent;
    b    = bits;
    node = int'(way) + PLRU_BITS;
    for (int l = 0; l < WAY_W; l++) begin
      parent = (node - 1) / 2;
      b      = b & ~(PLRU_BITS'(1) << parent);
      if (node % 2 == 1) b = b | (PLRU_BITS'(1) << parent);
      node   = parent;
    end
    return b;
  endfunction

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS_NUM; w++) begin
      hit_vec[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
    end
    for (int w = WAYS_NUM - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit       = |hit_vec;
  assign hit_instr = word_of(data_q[req_set][hit_way], req_word);

  always_comb begin
    victim_way = plru_victim(plru_q[miss_set]);
    for (int w = WAYS_NUM - 1; w >= 0; w--) begin
      if (!valid_q[miss_set][w]) victim_way = WAY_W'(w);
    end
  end

  assign rsp_match  = mem_rsp_valid && (mem_rsp_addr[31:OFFSET_W] == miss_pc_q[31:OFFSET_W]);
  assign fill_instr = word_of(mem_rsp_data, miss_word);

  always_comb begin
    state_d        = state_q;
    core_req_ready = 1'b0;
    mem_req_valid  = 1'b0;
    accept         = 1'b0;
    fill           = 1'b0;
    case (state_q)
      IDLE: begin
        core_req_ready = !flush;
        accept         = core_req_valid && !flush;
        if (accept && !hit) state_d = MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (rsp_match) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_addr = {miss_pc_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign state_dbg    = state_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q        <= IDLE;
      miss_pc_q      <= '0;
      core_rsp_valid <= 1'b0;
      core_rsp_instr <= '0;
      core_rsp_pc    <= '0;
      for (int s = 0; s < SETS_NUM; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      core_rsp_valid <= 1'b0;
      if (accept && hit) begin
        core_rsp_valid  <= 1'b1;
        core_rsp_instr  <= hit_instr;
        core_rsp_pc     <= core_req_pc;
        plru_q[req_set] <= plru_touch(plru_q[req_set], hit_way);
      end
      if (accept && !hit) miss_pc_q <= core_req_pc;
      if (fill) begin
        core_rsp_valid                 <= 1'b1;
        core_rsp_instr                 <= fill_instr;
        core_rsp_pc                    <= miss_pc_q;
        valid_q[miss_set][victim_way]  <= 1'b1;
        plru_q[miss_set]               <= plru_touch(plru_q[miss_set], victim_way);
      end
      // Flush is last so it overrides a same-cycle fill; the response above still goes out.
      if (flush) begin
        for (int s = 0; s < SETS_NUM; s++) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (fill && !flush) begin
      tag_q[miss_set][victim_way]  <= miss_tag;
      data_q[miss_set][victim_way] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_icache_sa.sv
// Directed bench for ifu_icache_sa: a line-level cache model with tree-PLRU decides
// hit/miss and the expected word; a scoreboard queue checks every core response.
module tb_ifu_icache_sa;

  localparam int CLW  = 128;
  localparam int WAYS = 4;
  localparam int SETS = 16;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           core_req_valid, core_req_ready, core_rsp_valid, flush;
  logic [31:0]    core_req_pc, core_rsp_instr, core_rsp_pc;
  logic           mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0]    mem_req_addr, mem_rsp_addr;
  logic [CLW-1:0] mem_rsp_data;
  logic [1:0]     state_dbg;

  ifu_icache_sa #(.CL_WIDTH(CLW), .WAYS_NUM(WAYS), .SETS_NUM(SETS)) dut (
    .Clk(Clk), .Rst(Rst),
    .core_req_valid(core_req_valid), .core_req_pc(core_req_pc), .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_instr(core_rsp_instr), .core_rsp_pc(core_rsp_pc),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
    .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cmp_e;
  logic [31:0] got;

  bit          m_valid [SETS][WAYS];
  logic [23:0] m_tag   [SETS][WAYS];
  bit          m_plru  [SETS][WAYS-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [CLW-1:0] line_data(input logic [31:0] line);
    logic [CLW-1:0] d;
    for (int i = 0; i < CLW / 32; i++) d[32*i +: 32] = mem_word(line + 32'(4 * i));
    return d;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
    end
  endtask

  function automatic int model_find(input int s, input logic [23:0] t);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  // Way w is the PLRU victim when every node on its root-to-leaf path points toward it.
  function automatic int model_victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    for (int w = 0; w < WAYS; w++) begin
      bit ok;
      ok = 1'b1;
      for (int l = 0; l < 2; l++) begin
        int node, dir;
        node = (1 << l) - 1 + (w >> (2 - l));
        dir  = (w >> (1 - l)) & 1;
        if (int'(m_plru[s][node]) != dir) ok = 1'b0;
      end
      if (ok) return w;
    end
    return 0;
  endfunction

  task automatic model_touch(input int s, input int w);
    for (int l = 0; l < 2; l++) begin
      int node, dir;
      node = (1 << l) - 1 + (w >> (2 - l));
      dir  = (w >> (1 - l)) & 1;
      m_plru[s][node] = (dir == 0);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && core_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual pc=%h instr=%h required=no response", core_rsp_pc, core_rsp_instr);
      end else begin
        cmp_e = exp_q.pop_front();
        check("rsp_pc", core_rsp_pc, cmp_e[63:32]);
        check("rsp_instr", core_rsp_instr, cmp_e[31:0]);
      end
    end
  end

  // One fetch; exp_hit is the hand-derived outcome, the model supplies the rest.
  task automatic fetch(input logic [31:0] pc, input bit exp_hit, input int ready_delay,
                       input bit wrong_first, input bit flush_fill, output logic [31:0] instr);
    int s, w, n;
    logic [31:0] line;
    s    = int'(pc[7:4]);
    line = pc & ~32'hF;
    w    = model_find(s, pc[31:8]);
    check($sformatf("model_pred_%h", pc), 32'(w >= 0), 32'(exp_hit));
    instr = 'x;
    @(posedge Clk); #1;
    core_req_valid = 1'b1;
    core_req_pc    = pc;
    n = 0;
    @(negedge Clk);
    while (!core_req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!core_req_ready) check("accept_timeout", 32'(core_req_ready), 32'd1);
    exp_q.push_back({pc, mem_word(pc)});
    @(posedge Clk); #1;
    core_req_valid = 1'b0;
    @(negedge Clk);
    check($sformatf("hit_%h", pc), 32'(core_rsp_valid), 32'(exp_hit));
    if (exp_hit) begin
      instr = core_rsp_instr;
      if (w >= 0) model_touch(s, w);
    end else begin
      check("mem_req_valid", 32'(mem_req_valid), 32'd1);
      check("mem_req_addr", mem_req_addr, line);
      check("ready_in_miss", 32'(core_req_ready), 32'd0);
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge Clk);
        check("stall_req_valid", 32'(mem_req_valid), 32'd1);
        check("stall_req_addr", mem_req_addr, line);
        check("stall_core_ready", 32'(core_req_ready), 32'd0);
      end
      mem_req_ready = 1'b1;
      @(posedge Clk); #1;
      mem_req_ready = 1'b0;
      if (wrong_first) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_addr  = line + 32'h1000;
        mem_rsp_data  = line_data(line + 32'h1000);
        @(negedge Clk);
        check("wait_req_valid", 32'(mem_req_valid), 32'd0);
        @(posedge Clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge Clk);
        check("wrong_rsp_ignored", 32'(core_rsp_valid), 32'd0);
        check("wrong_rsp_ready", 32'(core_req_ready), 32'd0);
        @(posedge Clk); #1;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_addr  = line;
      mem_rsp_data  = line_data(line);
      flush         = flush_fill;
      @(posedge Clk); #1;
      mem_rsp_valid = 1'b0;
      flush         = 1'b0;
      @(negedge Clk);
      check("fill_rsp_valid", 32'(core_rsp_valid), 32'd1);
      check("fill_ready_idle", 32'(core_req_ready), 32'd1);
      instr = core_rsp_instr;
      if (flush_fill) begin
        model_reset();
      end else begin
        w = model_victim(s);
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = pc[31:8];
        model_touch(s, w);
      end
    end
  endtask

  // Flush in IDLE with a simultaneous request, which must not be taken.
  task automatic do_flush(input logic [31:0] pc);
    @(posedge Clk); #1;
    flush          = 1'b1;
    core_req_valid = 1'b1;
    core_req_pc    = pc;
    @(negedge Clk);
    check("flush_blocks_ready", 32'(core_req_ready), 32'd0);
    @(posedge Clk); #1;
    flush          = 1'b0;
    core_req_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    core_req_valid = 1'b0;
    core_req_pc    = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_addr   = '0;
    mem_rsp_data   = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst_core_ready", 32'(core_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(core_rsp_valid), 32'd0);
    check("rst_rsp_instr", core_rsp_instr, 32'd0);
    check("rst_rsp_pc", core_rsp_pc, 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_req_addr, 32'd0);

    fetch(32'h1004, 1'b0, 0, 1'b0, 1'b0, got);
    check("first_miss_instr", got, 32'hDEAD_BEEF);
    fetch(32'h1004, 1'b1, 0, 1'b0, 1'b0, got);
    check("first_hit_instr", got, 32'hDEAD_BEEF);

    do_flush(32'h0000_1004);
    fetch(32'h000, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h100, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h200, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h300, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h000, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h208, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h10C, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h400, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h004, 1'b1, 0, 1'b0, 1'b0, got);
    check("lru_hit_instr", got, 32'h0004_000C ^ 32'hC0DE_0000);
    fetch(32'h300, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h400, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h100, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h200, 1'b0, 0, 1'b0, 1'b0, got);

    do_flush(32'h0000_1000);
    fetch(32'h1000, 1'b0, 0, 1'b1, 1'b0, got);
    fetch(32'h1000, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h2000, 1'b0, 0, 1'b0, 1'b0, got);

    fetch(32'h3008, 1'b0, 5, 1'b0, 1'b0, got);
    fetch(32'h3008, 1'b1, 0, 1'b0, 1'b0, got);

    do_flush(32'h0000_1000);
    fetch(32'h1000, 1'b0, 0, 1'b0, 1'b1, got);
    fetch(32'h1000, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h2000, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h1000, 1'b1, 0, 1'b0, 1'b0, got);
    fetch(32'h2000, 1'b1, 0, 1'b0, 1'b0, got);
    do_flush(32'h0000_2000);
    fetch(32'h1000, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h2000, 1'b0, 0, 1'b0, 1'b0, got);

    @(posedge Clk); #1;
    core_req_valid = 1'b1;
    core_req_pc    = 32'h5000;
    @(negedge Clk);
    check("rstmiss_ready", 32'(core_req_ready), 32'd1);
    @(posedge Clk); #1;
    core_req_valid = 1'b0;
    @(negedge Clk);
    check("rstmiss_memreq", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge Clk); #1;
    mem_req_ready = 1'b0;
    @(negedge Clk);
    check("rstmiss_in_wait", 32'(core_req_ready), 32'd0);
    #1 Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("rstmiss_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rstmiss_rsp_valid", 32'(core_rsp_valid), 32'd0);
    check("rstmiss_core_ready", 32'(core_req_ready), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = 32'h5000;
    mem_rsp_data  = line_data(32'h5000);
    @(posedge Clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge Clk);
    check("late_rsp_ignored", 32'(core_rsp_valid), 32'd0);
    model_reset();
    fetch(32'h5000, 1'b0, 0, 1'b0, 1'b0, got);
    fetch(32'h1000, 1'b0, 0, 1'b0, 1'b0, got);

    repeat (2) @(negedge Clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_icache_sa.md
Name: ifu_icache_sa

Overview:
- Parametrised set-associative instruction cache for the IFU; successor to the fixed 128-bit-line, 16-way fully-associative arrangement.
- Sits between the core fetch stage and instruction memory.
- Returns one 32-bit instruction per accepted PC and fills whole cache lines on a miss.
- Uses tree-PLRU replacement per set and supports a single-cycle invalidate-all flush.

Parameters:
- CL_WIDTH, 128: cache line width in bits; power of two, >=64. OFFSET_W = log2(CL_WIDTH/8).
- WAYS_NUM, 4: ways per set; power of two, >=2. PLRU_BITS = WAYS_NUM-1.
- SETS_NUM, 16: sets; power of two, >=1. INDEX_W = log2(SETS_NUM), may be 0.
- TAG_W, derived: 32-OFFSET_W-INDEX_W.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous active-high reset
- core_req_valid  in  1  fetch request
- core_req_pc  in  32  fetch PC, word aligned
- core_req_ready  out  1  request accepted when valid&ready
- core_rsp_valid  out  1  one-cycle response pulse
- core_rsp_instr  out  32  instruction
- core_rsp_pc  out  32  PC of the response
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  fill request
- mem_req_addr  out  32  line-aligned fill address (low OFFSET_W bits zero)
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  fill data valid
- mem_rsp_addr  in  32  address of returned line
- mem_rsp_data  in  CL_WIDTH  returned line

Behaviour:
- Address split: tag = pc[31:OFFSET_W+INDEX_W], index = pc[OFFSET_W+INDEX_W-1:OFFSET_W], word = pc[OFFSET_W-1:2].
- Storage: per set/way valid bit, TAG_W tag, CL_WIDTH data, all in flops. Per set PLRU_BITS.
- Reset values: all valid=0; PLRU=0; FSM=IDLE; core_rsp_valid=0; core_rsp_instr=0; core_rsp_pc=0; mem_req_valid=0; mem_req_addr=0. core_req_ready=1 in IDLE.
- FSM states: IDLE, MISS_REQ, MISS_WAIT.
  - IDLE: core_req_ready = !flush. On an accepted request, look up all ways of the set combinationally.
    - Hit: next cycle core_rsp_valid=1, with instr = word of the hit line and pc echoed. Hit latency is 1. Update PLRU. Stay in IDLE, so back-to-back hits give one response per cycle.
    - Miss: latch pc, then go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1, mem_req_addr = {pc[31:OFFSET_W], 0}, held stable until mem_req_ready. On handshake go to MISS_WAIT.
  - MISS_WAIT: wait for mem_rsp_valid with mem_rsp_addr[31:OFFSET_W] matching the latched line. Responses that do not match are ignored.
    - On a match: write the line into the victim way (tag, data, valid=1) and update PLRU.
    - Next cycle: core_rsp_valid=1 with the requested word taken from mem_rsp_data (latched), and return to IDLE.
- core_req_ready=0 in MISS_REQ and MISS_WAIT.
- Victim selection: the lowest-numbered invalid way if any exists; otherwise the tree-PLRU victim.
- Tree-PLRU encoding:
  - Node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Bit 0 means the victim is in the left subtree.
  - On access to a way, every node on its path is set to point away from it.
  - Example, 4 ways: access way0 sets b0=1, b1=1; the victim is then way2 or way3.
- Flush: clears every valid bit and PLRU bit in the cycle it is sampled.
  - If flush coincides with a MISS_WAIT fill write, flush wins: the line is not stored, but the core response is still delivered.
  - Flush does not abort MISS_REQ or MISS_WAIT.
- Simultaneous request and flush in IDLE: request is not accepted (ready=0).
- Rst mid-miss: FSM returns to IDLE immediately, mem_req_valid drops, no core response is produced, and all lines are invalid.
- Multiple hitting ways cannot occur; the design does not arbitrate them.

Test Plan:
- Reset, then request pc=0x0000_1004 -> miss. mem_req_addr=0x0000_1000; memory returns line with word1=0xDEADBEEF. Core gets rsp pc=0x1004, instr=0xDEADBEEF. A re-request gets the same response 1 cycle after acceptance (hit).
- Cold fill of 4 ways in set 0 (pcs 0x000, 0x100, 0x200, 0x300), then access 0x000, 0x200, 0x100. Fifth miss at 0x400 must evict way3 (line 0x300). A re-request of 0x300 misses; 0x000 still hits.
- During MISS_WAIT for 0x1000, memory returns addr 0x2000 first, then 0x1000 -> first response ignored; only 0x1000 is filled and responded.
- Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and addr stable, core_req_ready=0 throughout.
- Flush asserted in the same cycle as the fill write for 0x1000 -> core still gets the instruction; re-request of 0x1000 misses. A flush in IDLE after two fills makes both lines miss.
- Assert Rst while in MISS_WAIT -> mem_req_valid=0, core_rsp_valid=0, core_req_ready=1 next cycle; a late mem_rsp_valid is ignored.
